siw_mem_reader: RTL and testbench

Streaming read engine for one port of a `siw_memory_bram_*` dual-port memory. It generates a strided address sequence from a programmed base, stride and count, and absorbs the memory's fixed 2-cycle read latency. It returns the words on a valid/ready output stream with last-word marking. It sits between a BRAM port and a downstream datapath consumer, and is the read-side counterpart to the delayed-write path inside the BRAM wrapper.

---
 rtl/siw_mem_reader_pkg.sv | 16 +
 rtl/siw_mem_reader_fifo.sv | 52 +++++
 rtl/siw_mem_reader.sv | 161 ++++++++++++++++
 tb/tb_siw_mem_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siw_mem_reader_pkg.sv
// Shared types for the strided BRAM read engine: FSM states, read latency, in-flight tag.
package siw_mem_reader_pkg;
  localparam int RD_LAT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;
endpackage

// File: rtl/siw_mem_reader_fifo.sv
// Synchronous FIFO with occupancy count and sync clear; 1-cycle push-to-head, head shown combinationally.
// Push into a full FIFO is accepted only together with a pop; pop from empty is ignored.
module siw_mem_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop      = i_pop && (r_count != '0);
  assign w_push     = i_push && ((r_count != CW'(DEPTH)) || w_pop);
  assign o_head_dat = r_mem[r_rd];
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/siw_mem_reader.sv
// Strided BRAM read engine: start->first mem_enable 1 cycle, ->out_valid 4 cycles; issue is credit-limited
// so a stalled consumer stops fetching after FIFO_DEPTH words. SIW_MEM_READER_WRAP_EN adds a [base,top] address window.
module siw_mem_reader
  import siw_mem_reader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              siw_mem_reader_clk,
  input  logic              siw_mem_reader_reset_n,
  input  logic              siw_mem_reader_init,
  input  logic              siw_mem_reader_start,
  input  logic [ADDR_W-1:0] siw_mem_reader_base,
  input  logic [ADDR_W-1:0] siw_mem_reader_stride,
  input  logic [ADDR_W:0]   siw_mem_reader_count,
`ifdef SIW_MEM_READER_WRAP_EN
  input  logic [ADDR_W-1:0] siw_mem_reader_top,
`endif
  output logic              siw_mem_reader_busy,
  output logic              siw_mem_reader_done,
  output logic              siw_mem_reader_mem_enable,
  output logic [ADDR_W-1:0] siw_mem_reader_mem_address,
  input  logic [DATA_W-1:0] siw_mem_reader_mem_data,
  output logic              siw_mem_reader_out_valid,
  input  logic              siw_mem_reader_out_ready,
  output logic [DATA_W-1:0] siw_mem_reader_out_data,
  output logic              siw_mem_reader_out_last
);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_mem_address;
  logic              r_mem_enable;
  logic              r_mem_last;
  tag_t              r_tag [RD_LAT];

  logic [ADDR_W-1:0] w_next_address;
  logic [FCW-1:0]    w_fifo_count;
  logic              w_fifo_empty;
  logic [DATA_W:0]   w_fifo_head;
  logic              w_pop;
  logic [OCW-1:0]    w_inflight;
  logic [OCW-1:0]    w_occupancy;
  logic              w_credit;

`ifdef SIW_MEM_READER_WRAP_EN
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_top;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W:0]   w_window;

  always_comb begin
    w_sum          = {1'b0, r_mem_address} + {1'b0, r_stride};
    w_window       = {1'b0, r_top} - {1'b0, r_base} + (ADDR_W + 1)'(1);
    w_next_address = (w_sum > {1'b0, r_top}) ? ADDR_W'(w_sum - w_window) : ADDR_W'(w_sum);
  end
`else
  assign w_next_address = r_mem_address + r_stride;
`endif

  // Words already committed to land in the FIFO, counted against this cycle's pop so a
  // free-running consumer never sees a bubble.
  always_comb begin
    w_inflight = OCW'(r_mem_enable);
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + OCW'(r_tag[i].valid);
    w_occupancy = OCW'(w_fifo_count) - OCW'(w_pop) + w_inflight;
  end
  assign w_credit = (w_occupancy < OCW'(FIFO_DEPTH));

  always_ff @(posedge siw_mem_reader_clk or negedge siw_mem_reader_reset_n) begin
    if (!siw_mem_reader_reset_n) begin
      r_state       <= S_IDLE;
      r_mem_enable  <= 1'b0;
      r_mem_address <= '0;
      r_mem_last    <= 1'b0;
      r_remaining   <= '0;
      r_stride      <= '0;
`ifdef SIW_MEM_READER_WRAP_EN
      r_base        <= '0;
      r_top         <= '0;
`endif
    end else if (siw_mem_reader_init) begin
      r_state       <= S_IDLE;
      r_mem_enable  <= 1'b0;
      r_mem_address <= '0;
      r_mem_last    <= 1'b0;
      r_remaining   <= '0;
    end else begin
      r_mem_enable <= 1'b0;
      case (r_state)
        S_IDLE: if (siw_mem_reader_start) begin
          r_stride <= siw_mem_reader_stride;
`ifdef SIW_MEM_READER_WRAP_EN
          r_base   <= siw_mem_reader_base;
          r_top    <= siw_mem_reader_top;
`endif
          if (siw_mem_reader_count == '0) begin
            r_state <= S_DONE;
          end else begin
            // The first read issues straight from IDLE: the FIFO is always empty here.
            r_mem_enable  <= 1'b1;
            r_mem_address <= siw_mem_reader_base;
            r_mem_last    <= (siw_mem_reader_count == CNT_ONE);
            r_remaining   <= siw_mem_reader_count - CNT_ONE;
            r_state       <= (siw_mem_reader_count == CNT_ONE) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: if (w_credit) begin
          r_mem_enable  <= 1'b1;
          r_mem_address <= w_next_address;
          r_mem_last    <= (r_remaining == CNT_ONE);
          r_remaining   <= r_remaining - CNT_ONE;
          if (r_remaining == CNT_ONE) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_occupancy == '0) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge siw_mem_reader_clk or negedge siw_mem_reader_reset_n) begin
    if (!siw_mem_reader_reset_n) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else if (siw_mem_reader_init) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= {r_mem_enable, r_mem_last};
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  siw_mem_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk        (siw_mem_reader_clk),
    .rst_n      (siw_mem_reader_reset_n),
    .i_clear    (siw_mem_reader_init),
    .i_push     (r_tag[RD_LAT-1].valid),
    .i_push_dat ({r_tag[RD_LAT-1].last, siw_mem_reader_mem_data}),
    .i_pop      (w_pop),
    .o_head_dat (w_fifo_head),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  assign w_pop = siw_mem_reader_out_valid && siw_mem_reader_out_ready;

  assign siw_mem_reader_out_valid   = !w_fifo_empty;
  assign {siw_mem_reader_out_last, siw_mem_reader_out_data} = w_fifo_empty ? '0 : w_fifo_head;
  assign siw_mem_reader_busy        = (r_state != S_IDLE);
  assign siw_mem_reader_done        = (r_state == S_DONE);
  assign siw_mem_reader_mem_enable  = r_mem_enable;
  assign siw_mem_reader_mem_address = r_mem_address;
endmodule

// File: tb/tb_siw_mem_reader.sv
// Scoreboard bench for siw_mem_reader: a 2-cycle BRAM model, an arithmetic address/data model, and a monitor.
module tb_siw_mem_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] stride = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] top_v = '0;
  logic          busy, done, mem_en, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, out_data;

  logic [DW-1:0] mem [0:MSZ-1];
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  assign mem_data = d2;

  siw_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .siw_mem_reader_clk         (clk),
    .siw_mem_reader_reset_n     (rst_n),
    .siw_mem_reader_init        (init),
    .siw_mem_reader_start       (start),
    .siw_mem_reader_base        (base),
    .siw_mem_reader_stride      (stride),
    .siw_mem_reader_count       (count),
`ifdef SIW_MEM_READER_WRAP_EN
    .siw_mem_reader_top         (top_v),
`endif
    .siw_mem_reader_busy        (busy),
    .siw_mem_reader_done        (done),
    .siw_mem_reader_mem_enable  (mem_en),
    .siw_mem_reader_mem_address (mem_addr),
    .siw_mem_reader_mem_data    (mem_data),
    .siw_mem_reader_out_valid   (out_valid),
    .siw_mem_reader_out_ready   (out_ready),
    .siw_mem_reader_out_data    (out_data),
    .siw_mem_reader_out_last    (out_last)
  );

  always #5 clk = ~clk;

  // BRAM with two-cycle read latency; junk on the bus when not enabled.
  always @(posedge clk) begin
    d1 <= mem_en ? mem[mem_addr] : $urandom;
    d2 <= d1;
  end

  typedef struct { logic [DW-1:0] d; logic l; } word_t;
  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, c0 = 0;
  int n_done = 0, n_reads = 0, n_words = 0, exp_done = 0;
  int first_en = -1, first_vld = -1, last_hs = -1, done_cyc = -1;
  int rdy_mode = 1;

  function automatic void chk(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: addresses, output words, stability, credit bound and done.
  initial begin
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    word_t         w;
    pv = 0; pr = 0; pl = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_en) begin
          n_reads++;
          if (first_en < 0) first_en = cyc;
          if (addr_q.size() == 0) chk("unexpected_read", 1, 0);
          else chk("mem_address", mem_addr, addr_q.pop_front());
          chk("credit_bound", (n_reads - n_words) <= FD, 1);
        end
        if (out_valid) begin
          if (first_vld < 0) first_vld = cyc;
          if (pv && !pr) begin
            chk("hold_data", out_data, pd);
            chk("hold_last", out_last, pl);
          end
          if (out_ready) begin
            n_words++;
            last_hs = cyc;
            if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
            else begin
              w = exp_q.pop_front();
              chk("out_data", out_data, w.d);
              chk("out_last", out_last, w.l);
            end
          end
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
          chk("done_expected", exp_done, 1);
          chk("all_words_before_done", exp_q.size() + addr_q.size(), 0);
          exp_done = 0;
        end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
    end
  end

  task automatic push_model(input int b, input int s, input int n, input int t);
    int wsz;
`ifdef SIW_MEM_READER_WRAP_EN
    wsz = t - b + 1;
`else
    wsz = MSZ;
`endif
    for (int k = 0; k < n; k++) begin
      int a;
      a = (b + (k * s) % wsz) % MSZ;
      addr_q.push_back(AW'(a));
      exp_q.push_back('{d: mem[a], l: (k == n - 1)});
    end
  endtask

  task automatic do_start(input int b, input int s, input int n, input int t, input bit accept);
    @(posedge clk);
    #1;
    base = AW'(b); stride = AW'(s); count = (AW + 1)'(n); top_v = AW'(t);
    start = 1'b1;
    c0 = cyc; first_en = -1; first_vld = -1;
    if (accept) begin
      push_model(b, s, n, t);
      exp_done = 1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    bit seen;
    d0 = n_done;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk);
      if (n_done != d0) seen = 1;
    end
    chk("done_within_budget", seen, 1);
  endtask

  initial begin
    int r0, b, s, n, t, wv;
    for (int i = 0; i < MSZ; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_enable", mem_en, 0);
    chk("rst_mem_address", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic 4-word read with cycle-exact latency
    rdy_mode = 1;
    r0 = n_reads;
    do_start(32'h010, 1, 4, 32'h3FF, 1);
    wait_done(50);
    chk("t1_first_enable_cycle", first_en - c0, 1);
    chk("t1_first_valid_cycle", first_vld - c0, 4);
    chk("t1_last_handshake_cycle", last_hs - c0, 7);
    chk("t1_done_cycle", done_cyc - c0, 8);
    chk("t1_reads", n_reads - r0, 4);

`ifndef SIW_MEM_READER_WRAP_EN
    do_start(32'h3FE, 3, 3, 32'h3FF, 1);
    wait_done(50);
`else
    do_start(32'h100, 2, 4, 32'h103, 1);
    wait_done(50);
`endif

    // Backpressure: only FIFO_DEPTH reads while stalled
    rdy_mode = 0;
    r0 = n_reads;
    do_start(32'h055, 7, 8, 32'h3FF, 1);
    repeat (20) @(posedge clk);
    chk("bp_reads_stalled", n_reads - r0, FD);
    @(negedge clk);
    chk("bp_enable_low", mem_en, 0);
    rdy_mode = 1;
    wait_done(100);
    chk("bp_reads_total", n_reads - r0, 8);

    // Abort mid-run with reads in flight
    do_start(32'h200, 5, 10, 32'h3FF, 1);
    @(posedge clk);
    #1 init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    exp_q.delete(); addr_q.delete();
    exp_done = 0; n_reads = 0; n_words = 0;
    chk("init_busy", busy, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_mem_enable", mem_en, 0);
    repeat (10) @(posedge clk);
    do_start(32'h123, 2, 5, 32'h3FF, 1);
    wait_done(60);

    // Zero count, then a start while busy
    do_start(32'h077, 1, 0, 32'h3FF, 1);
    wait_done(10);
    chk("zero_done_cycle", done_cyc - c0, 1);
    r0 = n_reads;
    do_start(32'h040, 1, 4, 32'h3FF, 1);
    do_start(32'h300, 9, 6, 32'h3FF, 0);
    wait_done(50);
    repeat (10) @(posedge clk);
    chk("busy_start_ignored_reads", n_reads - r0, 4);

    // Full-range count
    do_start(0, 1, MSZ, MSZ - 1, 1);
    wait_done(MSZ + 50);

    // Random transfers with random backpressure
    rdy_mode = 2;
    for (int it = 0; it < 30; it++) begin
      b = $urandom_range(0, MSZ - 1);
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
`ifdef SIW_MEM_READER_WRAP_EN
      wv = $urandom_range(1, MSZ - b);
      t = b + wv - 1;
      s = $urandom_range(0, wv);
`else
      wv = 0;
      t = MSZ - 1;
      s = $urandom_range(0, MSZ - 1) + wv;
`endif
      do_start(b, s, n, t, 1);
      wait_done(400);
    end
    rdy_mode = 1;
    repeat (5) @(posedge clk);
    chk("final_queue_empty", exp_q.size() + addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "time budget exceeded");
  end
endmodule
